pal_line_scanner: RTL and testbench

Video-line fetch and pixel serializer sitting between the frame-buffer BRAM read port and the PAL level generator in the 159 MHz domain. At the start of every PAL line it maps the PAL line number to a frame-buffer row and reads that row from BRAM. When the active-video window opens, it emits one monochrome pixel per `PIXEL_TICKS` clocks. The PAL generator uses `pixel_white`/`pixel_active` in place of its built-in test pattern.

---
 rtl/pal_line_scanner_if.sv | 15 +
 rtl/pal_line_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_pal_line_scanner.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_line_scanner_if.sv
// pal_line_scanner_if
//   Frame-buffer BRAM read port between the line scanner and the BRAM.
//   bram_addr_rd : row address (scanner -> BRAM)
//   bram_data_rd : row data, DATA_W bits (BRAM -> scanner)
//   modport master : scanner side
//   modport slave  : BRAM side
interface pal_line_scanner_if #(
  parameter int DATA_W = 400
);
  logic [9:0]        bram_addr_rd;
  logic [DATA_W-1:0] bram_data_rd;

  modport master (output bram_addr_rd, input bram_data_rd);
  modport slave  (input bram_addr_rd, output bram_data_rd);
endinterface

// File: rtl/pal_line_scanner.sv
// pal_line_scanner
//   Fetches one frame-buffer row per PAL line and serializes it as monochrome
//   pixels, one per PIXEL_TICKS clocks, once the active-video window opens.
//   Ports:
//     clk, rst_n    : pixel clock, asynchronous active-low reset
//     line_start    : one-cycle pulse at tick 0 of each PAL line
//     line_num      : PAL line number 1..625, valid with line_start
//     active_start  : one-cycle pulse at start of active video
//     underrun_clr  : clears the sticky underrun flag
//     bram          : BRAM read port (pal_line_scanner_if.master)
//     pixel_active  : high while pixels are emitted
//     pixel_white   : current pixel level, 0 when not active
//     pixel_idx     : index of the current pixel
//     underrun      : sticky, fetch was still running at active_start
//   Build option: define PAL_SCAN_INTERLACE_EN for interlaced row mapping
//   (field 1 -> even rows, field 2 -> odd rows); otherwise both fields map
//   onto rows 0..LINES_PER_FIELD-1.
//
//   state | meaning
//   IDLE  | nothing to do until the next line_start
//   FETCH | row address issued, waiting RD_LAT clocks for BRAM data
//   READY | line buffered, waiting for active_start
//   SHIFT | emitting pixels
module pal_line_scanner #(
  parameter int PIXELS          = 300,
  parameter int DATA_W          = 400,
  parameter int RD_LAT          = 1,
  parameter int PIXEL_TICKS     = 27,
  parameter int FIELD1_FIRST    = 7,
  parameter int FIELD2_FIRST    = 320,
  parameter int LINES_PER_FIELD = 304
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [10:0]         line_num,
  input  logic                active_start,
  input  logic                underrun_clr,
  pal_line_scanner_if.master  bram,
  output logic                pixel_active,
  output logic                pixel_white,
  output logic [8:0]          pixel_idx,
  output logic                underrun
);

  localparam int CNT_MAX = (PIXEL_TICKS > RD_LAT) ? PIXEL_TICKS : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [10:0] F1_FIRST = 11'(FIELD1_FIRST);
  localparam logic [10:0] F1_LAST  = 11'(FIELD1_FIRST + LINES_PER_FIELD - 1);
  localparam logic [10:0] F2_FIRST = 11'(FIELD2_FIRST);
  localparam logic [10:0] F2_LAST  = 11'(FIELD2_FIRST + LINES_PER_FIELD - 1);
  localparam logic [8:0]  LAST_IDX = 9'(PIXELS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, READY, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [9:0]          addr_q, addr_d;
  logic [PIXELS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [8:0]          idx_q, idx_d;
  logic                active_q, active_d;
  logic                white_q, white_d;
  logic                underrun_q, underrun_d;
  // Set by an underrun: the line finishes its fetch but is not shown.
  logic                skip_q, skip_d;

  logic [DATA_W-1:0]   rd_word;
  logic [10:0]         off1, off2, row_full;
  logic                in_f1, in_f2, line_is_active;
  logic                unused_bits;

  assign rd_word = bram.bram_data_rd;

  assign off1  = line_num - F1_FIRST;
  assign off2  = line_num - F2_FIRST;
  assign in_f1 = (line_num >= F1_FIRST) && (line_num <= F1_LAST);
  assign in_f2 = (line_num >= F2_FIRST) && (line_num <= F2_LAST);
  assign line_is_active = (in_f1 || in_f2) && (line_num <= 11'd625);

`ifdef PAL_SCAN_INTERLACE_EN
  assign row_full = in_f1 ? (off1 << 1) : ((off2 << 1) | 11'd1);
`else
  assign row_full = in_f1 ? off1 : off2;
`endif

  generate
    if (DATA_W > PIXELS) begin : g_hi
      assign unused_bits = ^{row_full[10], rd_word[DATA_W-1:PIXELS]};
    end else begin : g_nohi
      assign unused_bits = row_full[10];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    active_d   = active_q;
    white_d    = white_q;
    underrun_d = underrun_q;
    skip_d     = skip_q;

    // Any set below overrides this clear.
    if (underrun_clr) underrun_d = 1'b0;

    if (line_start) begin
      active_d = 1'b0;
      white_d  = 1'b0;
      idx_d    = '0;
      skip_d   = 1'b0;
      if (line_is_active) begin
        addr_d  = row_full[9:0];
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = FETCH;
        // active_start coinciding with line_start lands inside the new fetch.
        if (active_start) begin
          underrun_d = 1'b1;
          skip_d     = 1'b1;
        end
      end else begin
        shreg_d = '0;
        state_d = READY;
      end
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          if (active_start) begin
            underrun_d = 1'b1;
            skip_d     = 1'b1;
          end
          if (cnt_q == '0) begin
            shreg_d = rd_word[PIXELS-1:0];
            state_d = READY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        READY: begin
          if (active_start && !skip_q) begin
            state_d  = SHIFT;
            active_d = 1'b1;
            white_d  = shreg_q[0];
            idx_d    = '0;
            cnt_d    = CNT_W'(PIXEL_TICKS - 1);
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              state_d  = IDLE;
              active_d = 1'b0;
              white_d  = 1'b0;
            end else begin
              idx_d   = idx_q + 9'd1;
              shreg_d = shreg_q >> 1;
              white_d = shreg_q[1];
              cnt_d   = CNT_W'(PIXEL_TICKS - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      active_q   <= 1'b0;
      white_q    <= 1'b0;
      underrun_q <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      active_q   <= active_d;
      white_q    <= white_d;
      underrun_q <= underrun_d;
      skip_q     <= skip_d;
    end
  end

  assign bram.bram_addr_rd = addr_q;
  assign pixel_active      = active_q;
  assign pixel_white       = white_q;
  assign pixel_idx         = idx_q;
  assign underrun          = underrun_q;

endmodule

// File: tb/tb_pal_line_scanner.sv
module tb_pal_line_scanner;

`ifdef PAL_SCAN_INTERLACE_EN
  localparam logic [9:0] R7 = 10'd0, R320 = 10'd1, R8 = 10'd2;
`else
  localparam logic [9:0] R7 = 10'd0, R320 = 10'd0, R8 = 10'd1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        line_start = 1'b0;
  logic [10:0] line_num = 11'd0;
  logic        active_start = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [299:0] pat = '0;
  logic [9:0]  tb_row = 10'd0;

  logic       act1, wht1, und1, act3, wht3, und3;
  logic [8:0] idx1, idx3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pal_line_scanner_if #(.DATA_W(400)) bif1 ();
  pal_line_scanner_if #(.DATA_W(400)) bif3 ();

  // BRAM model: the expected row returns the test pattern, any other row all-white.
  assign bif1.bram_data_rd = (bif1.bram_addr_rd == tb_row) ? {100'd0, pat} : {400{1'b1}};
  assign bif3.bram_data_rd = (bif3.bram_addr_rd == tb_row) ? {100'd0, pat} : {400{1'b1}};

  pal_line_scanner #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
    .active_start(active_start), .underrun_clr(underrun_clr), .bram(bif1.master),
    .pixel_active(act1), .pixel_white(wht1), .pixel_idx(idx1), .underrun(und1)
  );

  pal_line_scanner #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_num(line_num),
    .active_start(active_start), .underrun_clr(underrun_clr), .bram(bif3.master),
    .pixel_active(act3), .pixel_white(wht3), .pixel_idx(idx3), .underrun(und3)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_line(input int num);
    line_start = 1'b1;
    line_num   = 11'(num);
    step(1);
    line_start = 1'b0;
  endtask

  task automatic pulse_active();
    active_start = 1'b1;
    step(1);
    active_start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({act1, wht1, idx1, und1} !== 12'd0) begin errors++;
      $display("FAIL reset_dut1_outputs got=%h exp=0", {act1, wht1, idx1, und1}); end
    checks++; if (bif1.bram_addr_rd !== 10'd0) begin errors++;
      $display("FAIL reset_dut1_addr got=%0d exp=0", bif1.bram_addr_rd); end
    checks++; if ({act3, wht3, idx3, und3, bif3.bram_addr_rd} !== 22'd0) begin errors++;
      $display("FAIL reset_dut3_all got=%h exp=0", {act3, wht3, idx3, und3, bif3.bram_addr_rd}); end
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_addr_map();
    pulse_line(7);
    checks++; if (bif1.bram_addr_rd !== R7) begin errors++;
      $display("FAIL addr_line7 got=%0d exp=%0d", bif1.bram_addr_rd, R7); end
    pulse_line(320);
    checks++; if (bif1.bram_addr_rd !== R320) begin errors++;
      $display("FAIL addr_line320 got=%0d exp=%0d", bif1.bram_addr_rd, R320); end
    pulse_line(8);
    checks++; if (bif1.bram_addr_rd !== R8) begin errors++;
      $display("FAIL addr_line8 got=%0d exp=%0d", bif1.bram_addr_rd, R8); end
    step(4);
  endtask

  task automatic test_pixels();
    logic bad;
    logic exp_w;
    tb_row = R8;
    pat    = 300'b101;
    pulse_line(8);
    step(1);
    pulse_active();
    bad = 1'b0;
    for (int k = 1; k <= 8101; k++) begin
      if (k == 1) begin
        checks++; if (act1 !== 1'b1 || idx1 !== 9'd0) begin errors++;
          $display("FAIL pix_start active=%b idx=%0d exp active=1 idx=0", act1, idx1); end
      end
      if (k <= 8100 && !bad) begin
        exp_w = (k <= 27) || (k >= 55 && k <= 81);
        checks++; if (wht1 !== exp_w) begin errors++; bad = 1'b1;
          $display("FAIL pix_white clock=%0d got=%b exp=%b", k, wht1, exp_w); end
      end
      if (k == 28) begin
        checks++; if (idx1 !== 9'd1) begin errors++;
          $display("FAIL pix_idx28 got=%0d exp=1", idx1); end
      end
      if (k == 55) begin
        checks++; if (idx1 !== 9'd2) begin errors++;
          $display("FAIL pix_idx55 got=%0d exp=2", idx1); end
      end
      if (k == 8100) begin
        checks++; if (act1 !== 1'b1 || idx1 !== 9'd299) begin errors++;
          $display("FAIL pix_last active=%b idx=%0d exp active=1 idx=299", act1, idx1); end
      end
      if (k == 8101) begin
        checks++; if (act1 !== 1'b0 || wht1 !== 1'b0) begin errors++;
          $display("FAIL pix_end active=%b white=%b exp 0 0", act1, wht1); end
      end
      if (k < 8101) step(1);
    end
    checks++; if (und1 !== 1'b0) begin errors++;
      $display("FAIL pix_no_underrun got=%b exp=0", und1); end
    step(3);
  endtask

  task automatic test_blank();
    logic bad;
    pulse_line(3);
    checks++; if (bif1.bram_addr_rd !== R8) begin errors++;
      $display("FAIL blank_addr_hold got=%0d exp=%0d", bif1.bram_addr_rd, R8); end
    step(1);
    pulse_active();
    bad = 1'b0;
    for (int k = 1; k <= 8105; k++) begin
      if (!bad) begin
        checks++; if (wht1 !== 1'b0) begin errors++; bad = 1'b1;
          $display("FAIL blank_white clock=%0d got=%b exp=0", k, wht1); end
      end
      step(1);
    end
    pulse_line(700);
    checks++; if (bif1.bram_addr_rd !== R8) begin errors++;
      $display("FAIL blank700_addr got=%0d exp=%0d", bif1.bram_addr_rd, R8); end
    step(3);
  endtask

  task automatic test_underrun();
    logic bad;
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (und3 !== 1'b0) begin errors++;
      $display("FAIL urun_pre_clear got=%b exp=0", und3); end
    pulse_line(8);
    step(1);
    pulse_active();
    checks++; if (und3 !== 1'b1) begin errors++;
      $display("FAIL urun_set got=%b exp=1", und3); end
    checks++; if (und1 !== 1'b0) begin errors++;
      $display("FAIL urun_lat1_clear got=%b exp=0", und1); end
    bad = 1'b0;
    for (int k = 1; k <= 8200; k++) begin
      if (!bad) begin
        checks++; if (act3 !== 1'b0 || wht3 !== 1'b0) begin errors++; bad = 1'b1;
          $display("FAIL urun_blank clock=%0d active=%b white=%b exp 0 0", k, act3, wht3); end
      end
      step(1);
    end
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    checks++; if (und3 !== 1'b0) begin errors++;
      $display("FAIL urun_clr got=%b exp=0", und3); end
    step(2);
  endtask

  task automatic test_abort();
    logic found;
    pulse_line(8);
    step(1);
    pulse_active();
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (idx1 === 9'd150) found = 1'b1;
      else step(1);
    end
    checks++; if (!found) begin errors++;
      $display("FAIL abort_reach_idx150 got idx=%0d exp=150", idx1); end
    pulse_line(320);
    checks++; if (act1 !== 1'b0 || wht1 !== 1'b0) begin errors++;
      $display("FAIL abort_active active=%b white=%b exp 0 0", act1, wht1); end
    checks++; if (bif1.bram_addr_rd !== R320) begin errors++;
      $display("FAIL abort_new_fetch addr=%0d exp=%0d", bif1.bram_addr_rd, R320); end
    step(2);
    checks++; if (und1 !== 1'b0) begin errors++;
      $display("FAIL simul_pre got=%b exp=0", und1); end
    line_start   = 1'b1;
    line_num     = 11'd7;
    active_start = 1'b1;
    underrun_clr = 1'b1;
    step(1);
    line_start   = 1'b0;
    active_start = 1'b0;
    underrun_clr = 1'b0;
    checks++; if (und1 !== 1'b1) begin errors++;
      $display("FAIL simul_underrun got=%b exp=1", und1); end
    checks++; if (act1 !== 1'b0 || bif1.bram_addr_rd !== R7) begin errors++;
      $display("FAIL simul_fetch active=%b addr=%0d exp active=0 addr=%0d", act1, bif1.bram_addr_rd, R7); end
    step(1);
    pulse_active();
    step(2);
    checks++; if (act1 !== 1'b0) begin errors++;
      $display("FAIL simul_no_shift got=%b exp=0", act1); end
  endtask

  task automatic test_reset_mid_shift();
    pulse_line(8);
    step(1);
    pulse_active();
    step(100);
    checks++; if (act1 !== 1'b1 || und1 !== 1'b1) begin errors++;
      $display("FAIL rst_pre active=%b underrun=%b exp 1 1", act1, und1); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({act1, wht1, idx1, und1} !== 12'd0) begin errors++;
      $display("FAIL rst_async_outputs got=%h exp=0", {act1, wht1, idx1, und1}); end
    checks++; if (bif1.bram_addr_rd !== 10'd0) begin errors++;
      $display("FAIL rst_async_addr got=%0d exp=0", bif1.bram_addr_rd); end
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_addr_map();
    test_pixels();
    test_blank();
    test_underrun();
    test_abort();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
